// File: rtl/phys_free_list_if.sv
// Free-list bus between the rename/commit side and the physical-register free list.
//   master : rename + commit (drives alloc/free/retire/flush, consumes tags and count)
//   slave  : phys_free_list (supplies tags, alloc_ready and free_count)
// Signals:
//   flush                      rewind speculative head to committed head
//   alloc0_valid/alloc1_valid  rename slots taking a register this cycle
//   alloc_ready                at least two free entries
//   rd_phy_new_0/1             tags offered to rename slots 0/1
//   free0/1_valid, free0/1_phy tags returned by commit
//   retire0/1_valid            committed instructions that had allocated a register
//   free_count                 speculative free entries
interface phys_free_list_if #(
  parameter int unsigned PHY_WIDTH = 6,
  parameter int unsigned CNT_WIDTH = 6
);
  logic                 flush;
  logic                 alloc0_valid;
  logic                 alloc1_valid;
  logic                 alloc_ready;
  logic [PHY_WIDTH-1:0] rd_phy_new_0;
  logic [PHY_WIDTH-1:0] rd_phy_new_1;
  logic                 free0_valid;
  logic [PHY_WIDTH-1:0] free0_phy;
  logic                 free1_valid;
  logic [PHY_WIDTH-1:0] free1_phy;
  logic                 retire0_valid;
  logic                 retire1_valid;
  logic [CNT_WIDTH-1:0] free_count;

  modport master (
    output flush, alloc0_valid, alloc1_valid, free0_valid, free0_phy, free1_valid, free1_phy,
           retire0_valid, retire1_valid,
    input  alloc_ready, rd_phy_new_0, rd_phy_new_1, free_count
  );

  modport slave (
    input  flush, alloc0_valid, alloc1_valid, free0_valid, free0_phy, free1_valid, free1_phy,
           retire0_valid, retire1_valid,
    output alloc_ready, rd_phy_new_0, rd_phy_new_1, free_count
  );
endinterface

// File: rtl/phys_free_list.sv
// Physical-register free list. Circular list of DEPTH tags with a speculative head (rename
// allocation), a tail (commit frees) and a committed head used to roll back on flush.
// Ports:
//   clk    clock, all state on posedge
//   rst_n  asynchronous active-low reset
//   bus    phys_free_list_if.slave (alloc/free/retire/flush in; tags, ready, count out)
module phys_free_list #(
  parameter int unsigned ARCH_REGS = 32,
  parameter int unsigned PHY_REGS  = 64,
  parameter int unsigned PHY_WIDTH = $clog2(PHY_REGS),
  parameter int unsigned DEPTH     = PHY_REGS - ARCH_REGS
) (
  input  logic            clk,
  input  logic            rst_n,
  phys_free_list_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PHY_WIDTH-1:0] list_q [DEPTH];
  logic [PHY_WIDTH-1:0] list_d [DEPTH];
  logic [PtrW-1:0]      head_q, head_d;
  logic [PtrW-1:0]      tail_q, tail_d;
  logic [PtrW-1:0]      commit_head_q, commit_head_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [CntW-1:0]      commit_count_q, commit_count_d;

  logic       alloc_ready;
  logic [1:0] n_alloc;
  logic [1:0] n_free;
  logic [1:0] n_retire;

  // Tags are looked up combinationally from the registered head so rename sees them this cycle.
  always_comb begin
    alloc_ready      = (count_q >= CntW'(2));
    bus.alloc_ready  = alloc_ready;
    bus.free_count   = count_q;
    bus.rd_phy_new_0 = list_q[head_q];
    // alloc1 alone takes list[head]; with alloc0 it takes the next entry.
    bus.rd_phy_new_1 = list_q[head_q + PtrW'(bus.alloc0_valid)];
  end

  always_comb begin
    // Flush wins over allocation; a stalled rename (alloc_ready low) allocates nothing.
    if (alloc_ready && !bus.flush) begin
      n_alloc = {1'b0, bus.alloc0_valid} + {1'b0, bus.alloc1_valid};
    end else begin
      n_alloc = 2'd0;
    end
    n_free   = {1'b0, bus.free0_valid} + {1'b0, bus.free1_valid};
    n_retire = {1'b0, bus.retire0_valid} + {1'b0, bus.retire1_valid};
  end

  always_comb begin
    list_d = list_q;
    if (bus.free0_valid) begin
      list_d[tail_q] = bus.free0_phy;
    end
    if (bus.free1_valid) begin
      list_d[tail_q + PtrW'(bus.free0_valid)] = bus.free1_phy;
    end
  end

  always_comb begin
    tail_d         = tail_q + PtrW'(n_free);
    commit_head_d  = commit_head_q + PtrW'(n_retire);
    commit_count_d = commit_count_q - CntW'(n_retire) + CntW'(n_free);
    if (bus.flush) begin
      // Everything allocated past the committed head returns to the list in one cycle.
      head_d  = commit_head_d;
      count_d = commit_count_d;
    end else begin
      head_d  = head_q + PtrW'(n_alloc);
      count_d = count_q - CntW'(n_alloc) + CntW'(n_free);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        list_q[i] <= PHY_WIDTH'(ARCH_REGS + i);
      end
      head_q         <= '0;
      tail_q         <= '0;
      commit_head_q  <= '0;
      count_q        <= CntW'(DEPTH);
      commit_count_q <= CntW'(DEPTH);
    end else begin
      list_q         <= list_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      commit_head_q  <= commit_head_d;
      count_q        <= count_d;
      commit_count_q <= commit_count_d;
    end
  end

  // Usage errors from the commit side; the list does not try to recover from them.
  free_overflow_a : assert property (@(posedge clk) disable iff (!rst_n)
    (32'(count_q) + 32'(n_free) <= DEPTH))
    else $error("free list overflow");

  retire_underflow_a : assert property (@(posedge clk) disable iff (!rst_n)
    (32'(commit_count_q) >= 32'(n_retire)))
    else $error("retire underflow");

endmodule

// File: tb/tb_phys_free_list.sv
module tb_phys_free_list;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  phys_free_list_if bus ();

  phys_free_list dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit       fl, a0, a1, f0v;
    bit [5:0] f0p;
    bit       f1v;
    bit [5:0] f1p;
    bit       r0, r1;
    int       e_rd0, e_rd1, e_cnt, e_rdy;  // -1 = don't care
  } vec_t;

  vec_t vecs[$];

  // Reference model: tags in allocation order, not yet allocated / allocated but not retired.
  logic [5:0] spec_free[$];
  logic [5:0] inflight[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit fl, bit a0, bit a1, bit f0v, int f0p, bit f1v, int f1p,
                              bit r0, bit r1, int e_rd0, int e_rd1, int e_cnt, int e_rdy);
    vec_t v;
    v.fl = fl; v.a0 = a0; v.a1 = a1; v.f0v = f0v; v.f0p = 6'(f0p); v.f1v = f1v;
    v.f1p = 6'(f1p); v.r0 = r0; v.r1 = r1;
    v.e_rd0 = e_rd0; v.e_rd1 = e_rd1; v.e_cnt = e_cnt; v.e_rdy = e_rdy;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.flush         = v.fl;
    bus.alloc0_valid  = v.a0;
    bus.alloc1_valid  = v.a1;
    bus.free0_valid   = v.f0v;
    bus.free0_phy     = v.f0p;
    bus.free1_valid   = v.f1v;
    bus.free1_phy     = v.f1p;
    bus.retire0_valid = v.r0;
    bus.retire1_valid = v.r1;
  endtask

  // Called just after a negedge: drive, check outputs, then take one clock.
  task automatic apply(input vec_t v, input string tag);
    drive(v);
    #1;
    if (v.e_rd0 >= 0) chk({tag, ".rd0"}, int'(bus.rd_phy_new_0), v.e_rd0);
    if (v.e_rd1 >= 0) chk({tag, ".rd1"}, int'(bus.rd_phy_new_1), v.e_rd1);
    if (v.e_cnt >= 0) chk({tag, ".cnt"}, int'(bus.free_count), v.e_cnt);
    if (v.e_rdy >= 0) chk({tag, ".rdy"}, int'(bus.alloc_ready), v.e_rdy);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, -1, -1, -1, -1));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic model_reset();
    spec_free.delete();
    inflight.delete();
    for (int i = 0; i < 32; i++) spec_free.push_back(6'(32 + i));
  endtask

  initial begin
    vec_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, -1, -1, -1, -1);
    drive(idle);
    rst_n = 1'b0;

    // 1: reset state (alloc0 held so slot 1 shows the second tag; no clock effect in reset)
    #12;
    bus.alloc0_valid = 1'b1;
    #1;
    chk("reset.rd0", int'(bus.rd_phy_new_0), 32);
    chk("reset.rd1", int'(bus.rd_phy_new_1), 33);
    chk("reset.cnt", int'(bus.free_count), 32);
    chk("reset.rdy", int'(bus.alloc_ready), 1);
    bus.alloc0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 2 + 3: drain the list, then refill two tags across the tail wrap
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 32 + 2 * i, 33 + 2 * i, 32 - 2 * i, 1));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 32, 33, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 40, 1, 41, 0, 0, 32, 33, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 40, 41, 2, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, -1, -1, 0, 0));
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("tbl%0d", i));

    // 4: allocate four, retire two and flush in one cycle
    do_reset();
    apply(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 32, 33, 32, 1), "flush.a");
    apply(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 34, 35, 30, 1), "flush.b");
    apply(mk(1, 1, 1, 0, 0, 0, 0, 1, 1, 36, 37, 28, 1), "flush.c");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 34, 34, 30, 1), "flush.d");

    // 5: count=2, alloc two and free two in the same cycle
    do_reset();
    for (int i = 0; i < 15; i++) apply(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, -1, -1, -1, -1), "fill");
    apply(mk(0, 1, 1, 1, 50, 1, 51, 0, 0, 62, 63, 2, 1), "same.a");
    apply(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 50, 51, 2, 1), "same.b");

    // 6: asynchronous reset in the middle of a burst
    do_reset();
    for (int i = 0; i < 11; i++) apply(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, -1, -1, -1, -1), "burst");
    drive(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, -1, -1, -1, -1));
    #1;
    chk("areset.pre_cnt", int'(bus.free_count), 10);
    #1;
    rst_n = 1'b0;
    #1;
    chk("areset.rd0", int'(bus.rd_phy_new_0), 32);
    chk("areset.rd1", int'(bus.rd_phy_new_1), 33);
    chk("areset.cnt", int'(bus.free_count), 32);
    chk("areset.rdy", int'(bus.alloc_ready), 1);
    @(negedge clk);
    drive(idle);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized traffic against the queue model
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      vec_t v;
      int   nr, nf, maxr, maxf, commit_cnt, eff;
      v = idle;
      v.fl = ($urandom_range(0, 15) == 0);
      v.a0 = 1'($urandom);
      v.a1 = 1'($urandom);
      commit_cnt = spec_free.size() + inflight.size();
      maxr = (inflight.size() < 2) ? inflight.size() : 2;
      nr = $urandom_range(0, maxr);
      if (nr == 2) begin v.r0 = 1; v.r1 = 1; end
      else if (nr == 1) begin if ($urandom % 2) v.r0 = 1; else v.r1 = 1; end
      maxf = 32 - commit_cnt;
      if (maxf > 2) maxf = 2;
      nf = $urandom_range(0, maxf);
      v.f0p = 6'($urandom);
      v.f1p = 6'($urandom);
      if (nf == 2) begin v.f0v = 1; v.f1v = 1; end
      else if (nf == 1) begin if ($urandom % 2) v.f0v = 1; else v.f1v = 1; end

      drive(v);
      #1;
      chk("rnd.cnt", int'(bus.free_count), spec_free.size());
      chk("rnd.rdy", int'(bus.alloc_ready), int'(spec_free.size() >= 2));
      if (spec_free.size() >= 1) chk("rnd.rd0", int'(bus.rd_phy_new_0), int'(spec_free[0]));
      if (v.a0 && spec_free.size() >= 2)
        chk("rnd.rd1", int'(bus.rd_phy_new_1), int'(spec_free[1]));
      else if (!v.a0 && spec_free.size() >= 1)
        chk("rnd.rd1", int'(bus.rd_phy_new_1), int'(spec_free[0]));

      // Model update for this clock edge
      eff = (!v.fl && spec_free.size() >= 2) ? int'(v.a0) + int'(v.a1) : 0;
      for (int k = 0; k < nr; k++) void'(inflight.pop_front());
      for (int k = 0; k < eff; k++) inflight.push_back(spec_free.pop_front());
      if (v.f0v) spec_free.push_back(v.f0p);
      if (v.f1v) spec_free.push_back(v.f1p);
      if (v.fl) begin
        spec_free = {inflight, spec_free};
        inflight.delete();
      end
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
